// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial pattern detector:
// state-width helper, default pattern and legal pattern-length bounds.
package seq_det_pkg;

   // Legal range for the pattern length.
   localparam int PAT_W_MIN = 2;
   localparam int PAT_W_MAX = 16;

   // Reset pattern of the classic lab detector; MSB is the first bit received.
   localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;

   // Width of the state output: it must represent 0..pat_w matched bits.
   function automatic int sw_of(input int pat_w);
      return $clog2(pat_w + 1);
   endfunction

endpackage : seq_det_pkg

// File: rtl/seq_prefix_match.sv
// Combinational prefix/suffix matcher. For a candidate window whose
// newest bit is cand[0], it finds the longest tail of the window that
// equals the head of the pattern (o_k), and the longest such tail that
// is strictly shorter than the pattern (o_pps), used to resume after
// an overlapping match.
module seq_prefix_match
   import seq_det_pkg::*;
#(
   parameter int PAT_W = 4,
   parameter int SW    = sw_of(PAT_W)
) (
   input  logic [PAT_W-1:0] i_cand,
   input  logic [SW-1:0]    i_valid_len,
   input  logic [PAT_W-1:0] i_pat,
   output logic [SW-1:0]    o_k,
   output logic [SW-1:0]    o_pps
);

   // One hit flag per candidate length; index 0 (empty match) always holds.
   logic [PAT_W:1] w_hit;
   logic [SW-1:0]  w_k_chain   [0:PAT_W];
   logic [SW-1:0]  w_pps_chain [0:PAT_W];

   assign w_k_chain[0]   = '0;
   assign w_pps_chain[0] = '0;

   // Each length is compared independently; longer lengths sit later in
   // the chain, so the longest hit overrides all shorter ones. Lengths
   // beyond the number of valid history bits are never allowed to hit.
   for (genvar gi = 1; gi <= PAT_W; gi++) begin : g_len
      assign w_hit[gi] = (SW'(gi) <= i_valid_len) &&
                         (i_cand[gi-1:0] == i_pat[PAT_W-1 -: gi]);

      assign w_k_chain[gi] = w_hit[gi] ? SW'(gi) : w_k_chain[gi-1];

      // The proper prefix-suffix ignores the full-length match.
      if (gi < PAT_W) begin : g_proper
         assign w_pps_chain[gi] = w_hit[gi] ? SW'(gi) : w_pps_chain[gi-1];
      end else begin : g_full
         assign w_pps_chain[gi] = w_pps_chain[gi-1];
      end
   end

   assign o_k   = w_k_chain[PAT_W];
   assign o_pps = w_pps_chain[PAT_W];

endmodule : seq_prefix_match

// File: rtl/seq_detector_param.sv
// Parametrised Mealy-style serial pattern detector with a runtime-loadable
// pattern, overlap/non-overlap modes, sample enable and a saturating match
// counter. State is the number of pattern prefix bits currently matched;
// it is recomputed each sample from a short history of accepted bits.
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEFAULT_PATTERN),
   parameter int               CNT_W   = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in,
   input  logic                     en,
   input  logic                     overlap,
   input  logic                     load_pat,
   input  logic [PAT_W-1:0]         pat_in,
   input  logic                     clr_cnt,
   output logic                     out,
   output logic [sw_of(PAT_W)-1:0]  s,
   output logic [CNT_W-1:0]         match_cnt
);

   localparam int SW = sw_of(PAT_W);

   // Refuse to elaborate with a pattern length outside the supported range.
   if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
      $error("seq_detector_param: PAT_W out of range");
   end

   logic [PAT_W-1:0] r_pat;
   logic [PAT_W-2:0] r_hist;
   logic [SW-1:0]    r_fill;
   logic [SW-1:0]    r_s;
   logic             r_out;
   logic [CNT_W-1:0] r_cnt;

   logic [PAT_W-1:0] w_cand;
   logic [SW-1:0]    w_valid_len;
   logic [SW-1:0]    w_k;
   logic [SW-1:0]    w_pps;
   logic             w_match;
   logic [PAT_W-2:0] w_hist_next;
   logic [SW-1:0]    w_fill_next;
   logic             w_cnt_full;

   // Newest bit enters at the LSB; fill never exceeds PAT_W-1, so the
   // valid length fill+1 fits in SW bits.
   assign w_cand      = {r_hist, in};
   assign w_valid_len = r_fill + 1'b1;
   assign w_hist_next = w_cand[PAT_W-2:0];
   assign w_fill_next = (r_fill == SW'(PAT_W - 1)) ? r_fill : r_fill + 1'b1;
   assign w_match     = (w_k == SW'(PAT_W));
   assign w_cnt_full  = (r_cnt == {CNT_W{1'b1}});

   seq_prefix_match #(
      .PAT_W (PAT_W),
      .SW    (SW)
   ) u_match (
      .i_cand      (w_cand),
      .i_valid_len (w_valid_len),
      .i_pat       (r_pat),
      .o_k         (w_k),
      .o_pps       (w_pps)
   );

   // Detector state, registered match pulse and counter; priority is
   // reset > load_pat > en, and clr_cnt always wins over an increment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pat  <= PATTERN;
         r_hist <= '0;
         r_fill <= '0;
         r_s    <= '0;
         r_out  <= 1'b0;
         r_cnt  <= '0;
      end else begin
         if (load_pat) begin
            r_pat  <= pat_in;
            r_hist <= '0;
            r_fill <= '0;
            r_s    <= '0;
            r_out  <= 1'b0;
         end else if (en) begin
            r_out <= w_match;
            if (w_match && !overlap) begin
               // Matched bits are consumed; the next match needs PAT_W new bits.
               r_hist <= '0;
               r_fill <= '0;
               r_s    <= '0;
            end else begin
               r_hist <= w_hist_next;
               r_fill <= w_fill_next;
               r_s    <= w_match ? w_pps : w_k;
            end
         end else begin
            r_out <= 1'b0;
         end

         if (clr_cnt) begin
            r_cnt <= '0;
         end else if (!load_pat && en && w_match && !w_cnt_full) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign out       = r_out;
   assign s         = r_s;
   assign match_cnt = r_cnt;

endmodule : seq_detector_param
